sim_uart_monitor: RTL and testbench

Simulation-side 8N1 UART receiver that consumes the SoC's `uart_tx` line in the simulator top level. It recovers bytes and buffers them in a small FIFO. The C++ harness drains them through a valid/ready port and compares them against expected console output. The block is synthesizable and also usable as an on-board loopback checker. It has one clock and runs at the SoC's external clock rate.

---
 rtl/sim_uart_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_sim_uart_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_uart_monitor.sv
// 8N1 UART receiver for the simulator top level: synchronizes the SoC's tx line,
// recovers bytes and queues them in a small FIFO drained through a valid/ready port.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | half-bit wait, then confirm the start bit (high sample = glitch)
// DATA   | sample 8 data bits LSB first, one per bit period
// STOP   | sample the stop bit; high pushes the byte, low flags a frame error
// BREAK  | line held low after a bad stop bit; wait for it to return high
module sim_uart_monitor #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          uart_rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          clear_i
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;

  localparam logic [CW-1:0] HALF_C   = CW'(HALF);
  localparam logic [CW-1:0] RELOAD_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] DEPTH_C  = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic          sync1_q, sync2_q;
  logic          rx_s;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  logic          push;
  logic          ferr_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW-1:0] level;
  logic          full, empty;
  logic          pop, accept, drop;

  logic          ferr_q, ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // IDLE loads HALF (not HALF-1) because the decision edge is one cycle after the load.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_C;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            cnt_d   = RELOAD_C;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = RELOAD_C;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign level  = wptr_q - rptr_q;
  assign full   = (level == DEPTH_C);
  assign empty  = (level == '0);
  assign pop    = ready_i & ~empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem_q[wptr_q[AW-1:0]] <= shift_q;
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (ferr_set) begin
        ferr_q <= 1'b1;
      end else if (clear_i) begin
        ferr_q <= 1'b0;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clear_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign data_o      = mem_q[rptr_q[AW-1:0]];
  assign valid_o     = ~empty;
  assign level_o     = level;
  assign frame_err_o = ferr_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sim_uart_monitor.sv
// Bench for sim_uart_monitor (CPB=8, depth 4): a vector table of single frames,
// then hand-written sequences for latency, back-to-back, overflow, break, glitch and reset.
module tb_sim_uart_monitor;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       uart_rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] level_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic       clear_i;

  int total = 0;
  int bad   = 0;
  int first_n;
  int ferr_rises;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  sim_uart_monitor #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .uart_rx_i  (uart_rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .clear_i    (clear_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; line keeps the stop-bit level when it returns.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    uart_rx_i = stop;
    repeat (CPB) @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    uart_rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk(name, data_o, exp);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{din: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h55, exp_ferr: 1'b0};
    vecs[1] = '{din: 8'hA3, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA3, exp_ferr: 1'b0};
    vecs[2] = '{din: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h01, exp_ferr: 1'b0};
    vecs[3] = '{din: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h80, exp_ferr: 1'b0};
    vecs[4] = '{din: 8'hFF, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
    vecs[5] = '{din: 8'h00, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};

    rst_i     = 1'b1;
    uart_rx_i = 1'b1;
    ready_i   = 1'b0;
    clear_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst valid", valid_o, 0);
    chk("rst level", level_o, 0);
    chk("rst data", data_o, 0);
    chk("rst ferr", frame_err_o, 0);
    chk("rst ovf", overflow_o, 0);
    rst_i = 1'b0;
    idle(4);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].din, vecs[v].stop);
      idle(2 * CPB);
      chk($sformatf("vec%0d valid", v), valid_o, vecs[v].exp_valid);
      chk($sformatf("vec%0d ferr", v), frame_err_o, vecs[v].exp_ferr);
      if (vecs[v].exp_valid) begin
        pop_chk($sformatf("vec%0d data", v), vecs[v].exp_data);
      end
      clear_pulse();
      chk($sformatf("vec%0d empty", v), level_o, 0);
      chk($sformatf("vec%0d ferr clr", v), frame_err_o, 0);
    end

    // Latency: line driven low just before edge T; valid must first be present at T+80.
    first_n = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int n = 1; n <= 100; n++) begin
          @(negedge clk_i);
          if (valid_o && first_n == 0) first_n = n;
        end
      end
    join
    chk("latency", first_n, 80);
    chk("single data", data_o, 8'h55);
    chk("single level", level_o, 1);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk("single pop valid", valid_o, 0);
    chk("single pop level", level_o, 0);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA3, 1'b1);
    idle(2 * CPB);
    chk("b2b level", level_o, 3);
    chk("b2b ferr", frame_err_o, 0);
    chk("b2b ovf", overflow_o, 0);
    pop_chk("b2b byte0", 8'h00);
    pop_chk("b2b byte1", 8'hFF);
    pop_chk("b2b byte2", 8'hA3);
    chk("b2b drained", valid_o, 0);

    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
    idle(2 * CPB);
    chk("ovf level", level_o, 4);
    chk("ovf head", data_o, 8'h10);
    chk("ovf flag", overflow_o, 1);
    clear_pulse();
    chk("ovf cleared", overflow_o, 0);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("ovf byte%0d", i), 8'h10 + 8'(i));
    chk("ovf drained", valid_o, 0);

    ferr_rises = 0;
    fork
      begin
        send_frame(8'h3C, 1'b0);
        uart_rx_i = 1'b0;
        repeat (20 * CPB) @(negedge clk_i);
        idle(2 * CPB);
        send_frame(8'h7E, 1'b1);
        idle(2 * CPB);
      end
      begin
        for (int i = 0; i < 44 * CPB; i++) begin
          @(negedge clk_i);
          if (frame_err_o && !clear_i) begin
            ferr_rises++;
            clear_i = 1'b1;
          end else begin
            clear_i = 1'b0;
          end
        end
        clear_i = 1'b0;
      end
    join
    chk("break ferr count", ferr_rises, 1);
    chk("break level", level_o, 1);
    chk("break ferr clr", frame_err_o, 0);
    pop_chk("break 7E", 8'h7E);

    uart_rx_i = 1'b0;
    repeat (2) @(negedge clk_i);
    idle(3 * CPB);
    chk("glitch level", level_o, 0);
    chk("glitch ferr", frame_err_o, 0);
    chk("glitch ovf", overflow_o, 0);

    // Fill to 4, then pop exactly on the fifth byte's push edge (T+79).
    for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1);
    fork
      send_frame(8'h25, 1'b1);
      begin
        repeat (79) @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
      end
    join
    chk("pushpop level", level_o, 4);
    chk("pushpop ovf", overflow_o, 0);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("pushpop byte%0d", i), 8'h22 + 8'(i));
    chk("pushpop drained", valid_o, 0);

    send_frame(8'h33, 1'b0);
    idle(2 * CPB);
    send_frame(8'h42, 1'b1);
    idle(2 * CPB);
    chk("pre-rst level", level_o, 1);
    chk("pre-rst ferr", frame_err_o, 1);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (44) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst valid", valid_o, 0);
        chk("midrst level", level_o, 0);
        chk("midrst data", data_o, 0);
        chk("midrst ferr", frame_err_o, 0);
        chk("midrst ovf", overflow_o, 0);
      end
    join
    idle(2 * CPB);
    chk("post-rst level", level_o, 0);
    send_frame(8'h81, 1'b1);
    idle(2 * CPB);
    chk("post-rst valid", valid_o, 1);
    chk("post-rst count", level_o, 1);
    pop_chk("post-rst 81", 8'h81);
    chk("post-rst ferr", frame_err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
